// File: rtl/updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : updown_counter
//  Description : Parametrised up/down counter with synchronous load, a
//                programmable terminal value (max_val), and wrap or saturate
//                behaviour at the limits. Reports terminal count
//                combinationally and emits a registered one-cycle wrap pulse.
//                Optional macro UPDOWN_COUNTER_OVF_CNT_EN adds a 16-bit
//                saturating wrap-event counter output (wrap_cnt).
//  Revision    : 1.0 - initial release
// ============================================================================
module updown_counter #(
    parameter int WIDTH    = 8,
    parameter int RST_VAL  = 0,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_zero,
    output logic             wrap
`ifdef UPDOWN_COUNTER_OVF_CNT_EN
    ,
    output logic [15:0]      wrap_cnt
`endif
);

    // Reset value reduced to the counter width.
    localparam logic [WIDTH-1:0] c_rst_val  = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] c_zero     = '0;
    localparam logic [WIDTH-1:0] c_one      = WIDTH'(1);
    localparam bit               c_saturate = (SATURATE != 0);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;

    logic [WIDTH-1:0] w_load_clamped;
    logic [WIDTH-1:0] w_up_count;
    logic             w_up_wrap;
    logic [WIDTH-1:0] w_dn_count;
    logic             w_dn_wrap;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_wrap_nxt;
    logic             w_up_terminal;
    logic             w_dn_terminal;

    // A count above max_val (max_val lowered at run time) is treated as the
    // terminal case going up, so ">=" rather than "==" is used here.
    assign w_up_terminal = (r_count >= max_val);
    assign w_dn_terminal = (r_count == c_zero);

    // Load value is clamped into the legal range 0..max_val.
    always_comb begin
        w_load_clamped = load_val;
        if (load_val > max_val) begin
            w_load_clamped = max_val;
        end
    end

    // Next value and wrap flag for an upward step.
    always_comb begin
        w_up_count = r_count + c_one;
        w_up_wrap  = 1'b0;
        if (w_up_terminal) begin
            if (c_saturate) begin
                w_up_count = r_count;
            end else begin
                w_up_count = c_zero;
                w_up_wrap  = 1'b1;
            end
        end
    end

    // Next value and wrap flag for a downward step; a count above max_val
    // simply decrements.
    always_comb begin
        w_dn_count = r_count - c_one;
        w_dn_wrap  = 1'b0;
        if (w_dn_terminal) begin
            if (c_saturate) begin
                w_dn_count = r_count;
            end else begin
                w_dn_count = max_val;
                w_dn_wrap  = 1'b1;
            end
        end
    end

    // Arbitrate load > enable > hold.
    always_comb begin
        w_count_nxt = r_count;
        w_wrap_nxt  = 1'b0;
        if (load) begin
            w_count_nxt = w_load_clamped;
        end else if (enable) begin
            if (up_dn) begin
                w_count_nxt = w_up_count;
                w_wrap_nxt  = w_up_wrap;
            end else begin
                w_count_nxt = w_dn_count;
                w_wrap_nxt  = w_dn_wrap;
            end
        end
    end

    // Count and wrap-pulse registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= c_rst_val;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    assign count   = r_count;
    assign wrap    = r_wrap;
    assign at_max  = (r_count == max_val);
    assign at_zero = (r_count == c_zero);

`ifdef UPDOWN_COUNTER_OVF_CNT_EN
    logic [15:0] r_wrap_cnt;

    // Saturating count of wrap pulses; load clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrap_cnt <= 16'h0000;
        end else if (load) begin
            r_wrap_cnt <= 16'h0000;
        end else if (r_wrap && (r_wrap_cnt != 16'hFFFF)) begin
            r_wrap_cnt <= r_wrap_cnt + 16'h0001;
        end
    end

    assign wrap_cnt = r_wrap_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_updown_counter
//  Description : Scoreboard bench for updown_counter. A wrap-mode and a
//                saturate-mode instance share stimulus; expected values from
//                a reference model are queued per edge and popped after it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       up_dn;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] max_val;

    logic [7:0] count,   s_count;
    logic       at_max,  s_at_max;
    logic       at_zero, s_at_zero;
    logic       wrap,    s_wrap;
`ifdef UPDOWN_COUNTER_OVF_CNT_EN
    logic [15:0] wrap_cnt, s_wrap_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    updown_counter #(.WIDTH(8), .RST_VAL(0), .SATURATE(0)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .up_dn(up_dn),
        .load(load), .load_val(load_val), .max_val(max_val),
        .count(count), .at_max(at_max), .at_zero(at_zero), .wrap(wrap)
`ifdef UPDOWN_COUNTER_OVF_CNT_EN
        , .wrap_cnt(wrap_cnt)
`endif
    );

    updown_counter #(.WIDTH(8), .RST_VAL(0), .SATURATE(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .enable(enable), .up_dn(up_dn),
        .load(load), .load_val(load_val), .max_val(max_val),
        .count(s_count), .at_max(s_at_max), .at_zero(s_at_zero), .wrap(s_wrap)
`ifdef UPDOWN_COUNTER_OVF_CNT_EN
        , .wrap_cnt(s_wrap_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  cnt;
        logic        wrp;
        logic [7:0]  scnt;
        logic        swrp;
        logic [15:0] wcnt;
        logic [7:0]  maxv;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    // Reference model state
    logic [7:0]  m_cnt, m_scnt;
    logic        m_wrap;
    logic [15:0] m_wcnt;

    task automatic model(input bit sat, input logic [7:0] c,
                         output logic [7:0] nc, output logic nw);
        nw = 1'b0;
        nc = c;
        if (load) begin
            nc = (load_val > max_val) ? max_val : load_val;
        end else if (enable) begin
            if (up_dn) begin
                if (c >= max_val) begin
                    if (!sat) begin nc = 8'd0; nw = 1'b1; end
                end else begin
                    nc = c + 8'd1;
                end
            end else begin
                if (c == 8'd0) begin
                    if (!sat) begin nc = max_val; nw = 1'b1; end
                end else begin
                    nc = c - 8'd1;
                end
            end
        end
    endtask

    // Predict one edge, queue it, advance to just after the edge.
    task automatic cyc();
        exp_t x;
        logic sw;
        model(1'b0, m_cnt,  x.cnt,  x.wrp);
        model(1'b1, m_scnt, x.scnt, x.swrp);
        x.wcnt = load ? 16'd0 :
                 ((m_wrap && m_wcnt != 16'hFFFF) ? m_wcnt + 16'd1 : m_wcnt);
        x.maxv = max_val;
        sb.push_back(x);
        @(posedge clk);
        #1;
        sw     = x.swrp;
        m_cnt  = x.cnt;
        m_wrap = x.wrp;
        m_scnt = x.scnt;
        m_wcnt = x.wcnt;
        if (sw !== 1'b0) $display("[TB] note: saturate instance predicted wrap");
    endtask

    task automatic model_reset();
        m_cnt  = 8'd0;
        m_scnt = 8'd0;
        m_wrap = 1'b0;
        m_wcnt = 16'd0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; up_dn = 1'b1; load = 1'b0;
        load_val = 8'd0; max_val = 8'd9;
        repeat (10) @(posedge clk);
        #1;
        model_reset();
        n_tests++;
        if ({count, wrap, at_zero} !== {8'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_wrapmode: got cnt=%0d wrap=%b zero=%b, want 0/0/1", count, wrap, at_zero);
        end
        n_tests++;
        if ({s_count, s_wrap, s_at_zero} !== {8'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_satmode: got cnt=%0d wrap=%b zero=%b, want 0/0/1", s_count, s_wrap, s_at_zero);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_up_wrap();
        enable = 1'b1; up_dn = 1'b1; max_val = 8'd9;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            e = sb.pop_front();
            n_tests++;
            if ({count, wrap, at_max, at_zero} !== {e.cnt, e.wrp, e.cnt == e.maxv, e.cnt == 8'd0}) begin
                n_fail++;
                $display("FAIL up_wrap[%0d]: got cnt=%0d wrap=%b max=%b zero=%b, want cnt=%0d wrap=%b",
                         i, count, wrap, at_max, at_zero, e.cnt, e.wrp);
            end
            n_tests++;
            if ({s_count, s_wrap, s_at_max} !== {e.scnt, e.swrp, e.scnt == e.maxv}) begin
                n_fail++;
                $display("FAIL up_sat[%0d]: got cnt=%0d wrap=%b max=%b, want cnt=%0d wrap=%b",
                         i, s_count, s_wrap, s_at_max, e.scnt, e.swrp);
            end
            // Independent spot check of the documented sequence 1..9, 0(wrap)
            if (i == 10) begin
                n_tests++;
                if ({count, wrap} !== {8'd0, 1'b1}) begin
                    n_fail++;
                    $display("FAIL up_wrap_point: got cnt=%0d wrap=%b, want 0/1", count, wrap);
                end
            end
        end
    endtask

    // Runs a table of cycles comparing both instances.
    task automatic run_cmp(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            e = sb.pop_front();
            n_tests++;
            if ({count, wrap, at_max, at_zero} !== {e.cnt, e.wrp, e.cnt == e.maxv, e.cnt == 8'd0}) begin
                n_fail++;
                $display("FAIL %s_wrapmode[%0d]: got cnt=%0d wrap=%b max=%b zero=%b, want cnt=%0d wrap=%b",
                         name, i, count, wrap, at_max, at_zero, e.cnt, e.wrp);
            end
            n_tests++;
            if ({s_count, s_wrap, s_at_max, s_at_zero} !== {e.scnt, e.swrp, e.scnt == e.maxv, e.scnt == 8'd0}) begin
                n_fail++;
                $display("FAIL %s_satmode[%0d]: got cnt=%0d wrap=%b max=%b zero=%b, want cnt=%0d wrap=%b",
                         name, i, s_count, s_wrap, s_at_max, s_at_zero, e.scnt, e.swrp);
            end
        end
    endtask

    task automatic test_down_limit();
        max_val = 8'd200; load = 1'b1; load_val = 8'd0; enable = 1'b0;
        run_cmp("down_load0", 1);
        load = 1'b0; enable = 1'b1; up_dn = 1'b0;
        run_cmp("down_limit", 3);
        n_tests++;
        if (s_count !== 8'd0 || s_at_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL down_sat_hold: got cnt=%0d zero=%b, want 0/1", s_count, s_at_zero);
        end
    endtask

    task automatic test_load_clamp();
        max_val = 8'd100; load = 1'b1; load_val = 8'd250; enable = 1'b1; up_dn = 1'b1;
        run_cmp("load_clamp", 1);
        n_tests++;
        if ({count, wrap, s_count} !== {8'd100, 1'b0, 8'd100}) begin
            n_fail++;
            $display("FAIL load_clamp_value: got cnt=%0d wrap=%b scnt=%0d, want 100/0/100", count, wrap, s_count);
        end
        load = 1'b0;
    endtask

    task automatic test_updn_toggle();
        max_val = 8'd255; load = 1'b1; load_val = 8'd5;
        run_cmp("toggle_load", 1);
        load = 1'b0; enable = 1'b1; up_dn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            run_cmp("toggle", 3);
            up_dn = ~up_dn;
        end
        n_tests++;
        if (count !== 8'd5) begin
            n_fail++;
            $display("FAIL toggle_end: got cnt=%0d, want 5", count);
        end
        enable = 1'b0;
        run_cmp("toggle_hold", 3);
    endtask

    task automatic test_max_change();
        max_val = 8'd255; load = 1'b1; load_val = 8'd200; enable = 1'b0;
        run_cmp("maxchg_load", 1);
        load = 1'b0; max_val = 8'd50; enable = 1'b1; up_dn = 1'b1;
        run_cmp("maxchg_up", 2);
        max_val = 8'd255; load = 1'b1;
        run_cmp("maxchg_reload", 1);
        load = 1'b0; max_val = 8'd50; up_dn = 1'b0;
        run_cmp("maxchg_down", 2);
    endtask

    task automatic test_max_zero();
        max_val = 8'd0; load = 1'b1; load_val = 8'd7; enable = 1'b0;
        run_cmp("max0_load", 1);
        load = 1'b0; enable = 1'b1; up_dn = 1'b1;
        run_cmp("max0_up", 3);
        up_dn = 1'b0;
        run_cmp("max0_down", 3);
    endtask

    task automatic test_full_range();
        max_val = 8'd255; load = 1'b1; load_val = 8'd254;
        run_cmp("full_load", 1);
        load = 1'b0; enable = 1'b1; up_dn = 1'b1;
        run_cmp("full_up", 3);
        load = 1'b1; load_val = 8'd0;
        run_cmp("full_load0", 1);
        load = 1'b0; up_dn = 1'b0;
        run_cmp("full_down", 2);
    endtask

    task automatic test_async_reset();
        max_val = 8'd255; load = 1'b1; load_val = 8'd42; enable = 1'b0; up_dn = 1'b1;
        run_cmp("async_load", 1);
        load = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({count, wrap, s_count} !== {8'd0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL async_reset: got cnt=%0d wrap=%b scnt=%0d before edge, want 0/0/0", count, wrap, s_count);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        enable = 1'b1;
        run_cmp("async_resume", 2);
        n_tests++;
        if (count !== 8'd2) begin
            n_fail++;
            $display("FAIL async_resume_value: got cnt=%0d, want 2", count);
        end
    endtask

`ifdef UPDOWN_COUNTER_OVF_CNT_EN
    task automatic test_wrap_cnt();
        max_val = 8'd3; load = 1'b1; load_val = 8'd0; enable = 1'b0; up_dn = 1'b1;
        run_cmp("wcnt_load", 1);
        load = 1'b0; enable = 1'b1;
        for (int i = 0; i < 21; i++) begin
            if (i == 20) enable = 1'b0;
            cyc();
            e = sb.pop_front();
            n_tests++;
            if ({count, wrap, wrap_cnt} !== {e.cnt, e.wrp, e.wcnt}) begin
                n_fail++;
                $display("FAIL wrap_cnt_seq[%0d]: got cnt=%0d wrap=%b wcnt=%0d, want cnt=%0d wrap=%b wcnt=%0d",
                         i, count, wrap, wrap_cnt, e.cnt, e.wrp, e.wcnt);
            end
        end
        n_tests++;
        if (wrap_cnt !== 16'd5 || s_wrap_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL wrap_cnt_total: got %0d (sat %0d), want 5 (sat 0)", wrap_cnt, s_wrap_cnt);
        end
        load = 1'b1;
        run_cmp("wcnt_clear", 1);
        load = 1'b0;
        n_tests++;
        if (wrap_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL wrap_cnt_clear: got %0d, want 0", wrap_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_up_wrap();
        test_down_limit();
        test_load_clamp();
        test_updn_toggle();
        test_max_change();
        test_max_zero();
        test_full_range();
        test_async_reset();
`ifdef UPDOWN_COUNTER_OVF_CNT_EN
        test_wrap_cnt();
`endif
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion by 200000, want finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
